dmem_responder: RTL and testbench

- Memory-side responder for the processor's data-memory interface: the far end of the CPU's memread/memwrite requests.
- Accepts one load/store request at a time over a valid/ready handshake.
- Inserts a programmable number of wait states, then performs the word access on an internal RAM.
- Returns read data and an error flag over a valid/ready response channel.
- Lets the core be exercised against a realistic multi-cycle memory instead of an ideal zero-latency array.

---
 rtl/dmem_responder.sv | 85 ++++++++
 tb/tb_dmem_responder.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: wait-stated word RAM behind valid/ready request and response channels
module dmem_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t r_state, w_next;
  logic [7:0] r_cnt;
  logic r_write, r_err;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic [3:0] r_be;
  logic [31:0] r_mem [2**ADDR_W];
  logic w_idle, w_accept, w_access, w_write, w_err;
  logic [31:0] w_addr, w_wdata;
  logic [3:0] w_be;
  logic [ADDR_W-1:0] w_idx;
  assign w_idle   = r_state == IDLE;
  assign w_accept = w_idle && req_valid;
  // with no wait states the access uses the live request at its accept edge
  assign w_access = reset && (WAIT_CYCLES == 0 ? w_accept : (r_state == WAIT && r_cnt == '0));
  assign w_write  = w_idle ? req_write : r_write;
  assign w_addr   = w_idle ? req_addr  : r_addr;
  assign w_wdata  = w_idle ? req_wdata : r_wdata;
  assign w_be     = w_idle ? req_be    : r_be;
  assign w_err    = (|w_addr[1:0]) || (|w_addr[31:ADDR_W+2]);
  assign w_idx    = w_addr[ADDR_W+1:2];
  assign req_ready = w_idle;
  assign rsp_valid = r_state == RESP;
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;
  always_comb begin
    w_next = r_state;
    w_next = w_idle ? (req_valid ? (WAIT_CYCLES == 0 ? RESP : WAIT) : IDLE)
           : r_state == WAIT ? (r_cnt == '0 ? RESP : WAIT)
           : (rsp_ready ? IDLE : RESP);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_write <= req_write;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_be    <= req_be;
        r_cnt   <= 8'(WAIT_CYCLES - 1);
      end else if (r_state == WAIT) begin
        r_cnt <= r_cnt - 8'd1;
      end
      if (w_access) begin
        r_rdata <= (w_err || w_write) ? '0 : r_mem[w_idx];
        r_err   <= w_err;
      end else if (rsp_valid && rsp_ready) begin
        r_rdata <= '0;
        r_err   <= 1'b0;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (w_access && w_write && !w_err)
      for (int i = 0; i < 4; i++)
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: two responders (2 and 0 wait states) checked against a transaction-level memory model
module tb_dmem_responder;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic req_valid [2], req_ready [2], req_write [2], rsp_valid [2], rsp_ready [2], rsp_err [2];
  logic [31:0] req_addr [2], req_wdata [2], rsp_rdata [2];
  logic [3:0] req_be [2];
  int ncmp = 0, nfail = 0;
  int wc [2] = '{2, 0};
  bit busy [2], resp [2];
  int n [2];
  logic m_wr [2], m_err [2];
  logic [31:0] m_a [2], m_wd [2], m_rd [2];
  logic [3:0] m_be [2];
  logic [31:0] mm [2][1024];

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(2)) u0 (
    .clk(clk), .reset(reset), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]));
  dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) u1 (
    .clk(clk), .reset(reset), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic access(input int d);
    m_rd[d] = '0;
    m_err[d] = (m_a[d][1:0] != 2'b0) || (m_a[d][31:12] != 20'b0);
    if (!m_err[d]) begin
      if (m_wr[d]) begin
        for (int b = 0; b < 4; b++)
          if (m_be[d][b]) mm[d][m_a[d][11:2]][8*b +: 8] = m_wd[d][8*b +: 8];
      end else m_rd[d] = mm[d][m_a[d][11:2]];
    end
    resp[d] = 1'b1;
  endtask

  always @(posedge clk or negedge reset) begin
    for (int d = 0; d < 2; d++) begin
      if (!reset) begin
        busy[d] = 1'b0;
        resp[d] = 1'b0;
      end else if (!busy[d]) begin
        if (req_valid[d]) begin
          busy[d] = 1'b1;
          n[d] = 0;
          m_wr[d] = req_write[d];
          m_a[d] = req_addr[d];
          m_wd[d] = req_wdata[d];
          m_be[d] = req_be[d];
          if (wc[d] == 0) access(d);
        end
      end else if (!resp[d]) begin
        n[d]++;
        if (n[d] == wc[d]) access(d);
      end else if (rsp_ready[d]) begin
        busy[d] = 1'b0;
        resp[d] = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("req_ready%0d", d), req_ready[d], !reset ? 1'b1 : !busy[d]);
      chk($sformatf("rsp_valid%0d", d), rsp_valid[d], reset && resp[d]);
      chk($sformatf("rsp_rdata%0d", d), rsp_rdata[d], (reset && resp[d]) ? m_rd[d] : 32'h0);
      chk($sformatf("rsp_err%0d", d), rsp_err[d], reset && resp[d] && m_err[d]);
    end
  end

  task automatic txn(input int d, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] be, input logic [31:0] xr, input logic xe, input int hold,
                     output int waits);
    int lat;
    req_write[d] = wr;
    req_addr[d] = a;
    req_wdata[d] = wd;
    req_be[d] = be;
    req_valid[d] = 1'b1;
    waits = 0;
    while (!req_ready[d] && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    chk("accept_bound", waits < 20, 1);
    @(negedge clk);
    req_valid[d] = 1'b0;
    req_write[d] = ~wr;
    req_addr[d] = ~a;
    req_wdata[d] = ~wd;
    req_be[d] = ~be;
    lat = 1;
    while (!rsp_valid[d] && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, wc[d] + 1);
    chk("lit_rdata", rsp_rdata[d], xr);
    chk("lit_err", rsp_err[d], xe);
    if (hold > 0) begin
      req_valid[d] = 1'b1;
      repeat (hold) @(negedge clk);
      chk("bp_valid", rsp_valid[d], 1);
      chk("bp_rdata", rsp_rdata[d], xr);
      chk("bp_ready", req_ready[d], 0);
    end
    rsp_ready[d] = 1'b1;
    @(negedge clk);
    rsp_ready[d] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w, cnt;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0;
      req_write[d] = 1'b0;
      req_addr[d] = '0;
      req_wdata[d] = '0;
      req_be[d] = '0;
      rsp_ready[d] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_req_ready", req_ready[d], 1);
      chk("rst_rsp_valid", rsp_valid[d], 0);
      chk("rst_rdata", rsp_rdata[d], 0);
      chk("rst_err", rsp_err[d], 0);
    end
    @(posedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    txn(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 0, 0, w);
    txn(0, 0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 0, 0, w);
    txn(0, 1, 32'h10, 32'h11223344, 4'h5, 32'h0, 0, 0, w);
    txn(0, 0, 32'h10, 32'h0, 4'h0, 32'hDE22BE44, 0, 0, w);
    txn(0, 1, 32'h10, 32'h99999999, 4'h0, 32'h0, 0, 0, w);
    txn(0, 0, 32'h10, 32'h0, 4'hF, 32'hDE22BE44, 0, 0, w);
    txn(0, 0, 32'h12, 32'h0, 4'h0, 32'h0, 1, 0, w);
    txn(0, 1, 32'h0, 32'hA5A5A5A5, 4'hF, 32'h0, 0, 0, w);
    txn(0, 1, 32'h1000, 32'hFFFFFFFF, 4'hF, 32'h0, 1, 0, w);
    txn(0, 0, 32'h0, 32'h0, 4'h0, 32'hA5A5A5A5, 0, 0, w);
    txn(0, 0, 32'h10, 32'h0, 4'h0, 32'hDE22BE44, 0, 5, w);
    txn(0, 0, 32'h0, 32'h0, 4'h0, 32'hA5A5A5A5, 0, 0, w);
    chk("bp_next_accept_wait", w, 0);
    txn(0, 1, 32'h20, 32'h0, 4'hF, 32'h0, 0, 0, w);
    req_write[0] = 1'b1;
    req_addr[0] = 32'h20;
    req_wdata[0] = 32'hCAFEF00D;
    req_be[0] = 4'hF;
    req_valid[0] = 1'b1;
    @(posedge clk);
    #2 req_valid[0] = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_req_ready", req_ready[0], 1);
    chk("mid_rst_rsp_valid", rsp_valid[0], 0);
    chk("mid_rst_rdata", rsp_rdata[0], 0);
    chk("mid_rst_err", rsp_err[0], 0);
    @(posedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    txn(0, 0, 32'h20, 32'h0, 4'h0, 32'h0, 0, 0, w);
    txn(1, 1, 32'h40, 32'h12345678, 4'hF, 32'h0, 0, 0, w);
    txn(1, 0, 32'h40, 32'h0, 4'h0, 32'h12345678, 0, 0, w);
    req_write[1] = 1'b0;
    req_addr[1] = 32'h40;
    req_valid[1] = 1'b1;
    rsp_ready[1] = 1'b1;
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid[1]) cnt++;
    end
    chk("b2b_responses", cnt, 4);
    req_valid[1] = 1'b0;
    @(negedge clk);
    rsp_ready[1] = 1'b0;
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
